// File: rtl/dm_arbiter_if.sv
// Bundle of requester-side and DM-side signals around the data-memory arbiter.
interface dm_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_we;
  logic [DATA_W-1:0]         mem_rdata;

  // Arbiter view.
  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_rdata,
    output gnt, done, rdata, busy, mem_addr, mem_wdata, mem_we
  );

  // Requesters plus DM view.
  modport master (
    output req, req_we, req_addr, req_wdata, mem_rdata,
    input  gnt, done, rdata, busy, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between NUM_REQ
// requesters; one load or store in flight at a time.
module dm_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RD_LAT  = 1
) (
  input logic             clk,
  input logic             rst,
  dm_arbiter_if.slave     bus
);
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   win_q;
  logic               we_q;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               mem_we_q;
  logic               busy_q;

  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   cand;
  logic               found;

  // Round-robin pick: first set request starting just after the last winner.
  always_comb begin
    win   = last;
    cand  = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last) + k) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= IDX_W'(NUM_REQ - 1);
      win_q    <= '0;
      we_q     <= 1'b0;
      cnt      <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mem_we_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      gnt_q    <= '0;
      done_q   <= '0;
      mem_we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            win_q    <= win;
            we_q     <= bus.req_we[win];
            addr_q   <= bus.req_addr[win*ADDR_W +: ADDR_W];
            wdata_q  <= bus.req_wdata[win*DATA_W +: DATA_W];
            last     <= win;
            gnt_q    <= NUM_REQ'(1) << win;
            mem_we_q <= bus.req_we[win];
            busy_q   <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (we_q) begin
            done_q <= NUM_REQ'(1) << win_q;
            state  <= RESP;
          end else begin
            cnt   <= CNT_W'(RD_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rdata_q <= bus.mem_rdata;
            done_q  <= NUM_REQ'(1) << win_q;
            state   <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  // Write strobe is registered, but a reset arriving in the ISSUE cycle must
  // still kill the store in that same cycle, so it is gated by rst directly.
  assign bus.mem_we    = mem_we_q & ~rst;
endmodule
